// File: rtl/axis_in_mch_if.sv
// rtl/axis_in_mch_if.sv - AXI4-Stream coefficient input bundle for axis_in_mch
interface axis_in_mch_if #(
  parameter int D_WIDTH = 16
);
  logic [D_WIDTH-1:0] tdata;
  logic               tvalid;
  logic               tlast;
  logic               tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_in_mch.sv
// rtl/axis_in_mch.sv - multi-polynomial AXIS loader with zero padding and banked addressing
// Optional macro AXIS_IN_ERR_EN adds sticky err_short / err_long flags.
module axis_in_mch #(
  parameter int N       = 541,
  parameter int M       = 1,
  parameter int D_WIDTH = 16,
  parameter int NCH     = 2,
  localparam int HW     = (N > 2) ? $clog2(N) : 1,
  localparam int NB     = (N + M - 1) / M,
  localparam int AHW    = (NB > 1) ? $clog2(NB) : 1,
  localparam int LW     = (M > 1) ? $clog2(M) : 1,
  localparam int MW     = (M == 1) ? HW : AHW + LW,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  axis_in_mch_if.slave       din,
  output logic [D_WIDTH-1:0] write_data,
  output logic [HW-1:0]      write_addr_h,
  output logic [MW-1:0]      write_addr_m,
  output logic [CW-1:0]      write_ch,
  output logic               write_en,
  output logic               write_done
`ifdef AXIS_IN_ERR_EN
  ,
  output logic               err_short,
  output logic               err_long
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, PAD, DONE} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] ptr;
  logic [CW-1:0] ch;
  logic          step;
  logic          ch_end;
  logic          pad_enter;
  logic          last_idx;
  logic          last_ch;

  assign last_idx = (ptr == HW'(N - 1));
  assign last_ch  = (ch == CW'(NCH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    din.tready = 1'b0;
    write_en   = 1'b0;
    write_data = '0;
    write_done = 1'b0;
    step       = 1'b0;
    ch_end     = 1'b0;
    pad_enter  = 1'b0;
    unique case (state)
      IDLE: begin
        if (din.tvalid) state_nxt = WRITE;
      end
      WRITE: begin
        din.tready = 1'b1;
        write_en   = din.tvalid;
        write_data = din.tdata;
        if (din.tvalid) begin
          // a full channel ends on its last index regardless of tlast
          if (last_idx) begin
            ch_end = 1'b1;
          end else begin
            step = 1'b1;
            if (din.tlast) begin
              pad_enter = 1'b1;
              state_nxt = PAD;
            end
          end
        end
      end
      PAD: begin
        write_en = 1'b1;
        if (last_idx) ch_end = 1'b1;
        else          step   = 1'b1;
      end
      DONE: begin
        write_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (ch_end) state_nxt = last_ch ? DONE : WRITE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      ch  <= '0;
    end else if (ch_end) begin
      ptr <= '0;
      ch  <= last_ch ? '0 : ch + CW'(1);
    end else if (step) begin
      ptr <= ptr + HW'(1);
    end
  end

  assign write_addr_h = ptr;
  assign write_ch     = ch;

  generate
    if (M == 1) begin : g_linear
      assign write_addr_m = ptr;
    end else begin : g_bank
      logic [AHW-1:0] a_hi;
      logic [LW-1:0]  a_lo;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_hi <= '0;
          a_lo <= '0;
        end else if (ch_end) begin
          a_hi <= '0;
          a_lo <= '0;
        end else if (step) begin
          if (a_lo == LW'(M - 1)) begin
            a_lo <= '0;
            a_hi <= a_hi + AHW'(1);
          end else begin
            a_lo <= a_lo + LW'(1);
          end
        end
      end

      assign write_addr_m = {a_hi, a_lo};
    end
  endgenerate

`ifdef AXIS_IN_ERR_EN
  logic frame_start;
  assign frame_start = (state == IDLE) && din.tvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (frame_start) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      if (pad_enter) err_short <= 1'b1;
      // a padded channel ends from PAD, so only a real final beat can be long
      if (ch_end && last_ch && (state == WRITE) && !din.tlast) err_long <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_in_mch.sv
// tb/tb_axis_in_mch.sv - directed self-checking bench for axis_in_mch (three configurations)
module tb_axis_in_mch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [1:0]  sel = 2'd0;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  axis_in_mch_if #(.D_WIDTH(16)) if0 ();
  axis_in_mch_if #(.D_WIDTH(16)) if1 ();
  axis_in_mch_if #(.D_WIDTH(16)) if2 ();

  assign if0.tdata  = tdata;
  assign if0.tlast  = tlast;
  assign if0.tvalid = tvalid & (sel == 2'd0);
  assign if1.tdata  = tdata;
  assign if1.tlast  = tlast;
  assign if1.tvalid = tvalid & (sel == 2'd1);
  assign if2.tdata  = tdata;
  assign if2.tlast  = tlast;
  assign if2.tvalid = tvalid & (sel == 2'd2);

  logic [15:0] wd0, wd1, wd2;
  logic [2:0]  ah0, ah1, ah2;
  logic [2:0]  am0, am2;
  logic [3:0]  am1;
  logic        c0, c1, c2;
  logic        en0, en1, en2;
  logic        dn0, dn1, dn2;
`ifdef AXIS_IN_ERR_EN
  logic        es0, es1, es2, el0, el1, el2;
`endif

  axis_in_mch #(.N(8), .M(1), .D_WIDTH(16), .NCH(1)) u0 (
    .clk(clk), .reset(reset), .din(if0),
    .write_data(wd0), .write_addr_h(ah0), .write_addr_m(am0), .write_ch(c0),
    .write_en(en0), .write_done(dn0)
`ifdef AXIS_IN_ERR_EN
    , .err_short(es0), .err_long(el0)
`endif
  );

  axis_in_mch #(.N(8), .M(3), .D_WIDTH(16), .NCH(1)) u1 (
    .clk(clk), .reset(reset), .din(if1),
    .write_data(wd1), .write_addr_h(ah1), .write_addr_m(am1), .write_ch(c1),
    .write_en(en1), .write_done(dn1)
`ifdef AXIS_IN_ERR_EN
    , .err_short(es1), .err_long(el1)
`endif
  );

  axis_in_mch #(.N(8), .M(1), .D_WIDTH(16), .NCH(2)) u2 (
    .clk(clk), .reset(reset), .din(if2),
    .write_data(wd2), .write_addr_h(ah2), .write_addr_m(am2), .write_ch(c2),
    .write_en(en2), .write_done(dn2)
`ifdef AXIS_IN_ERR_EN
    , .err_short(es2), .err_long(el2)
`endif
  );

  logic        o_rdy, o_en, o_ch, o_done;
  logic [15:0] o_data;
  logic [2:0]  o_ah;
  logic [3:0]  o_am;
`ifdef AXIS_IN_ERR_EN
  logic        o_es, o_el;
`endif

  always_comb begin
    case (sel)
      2'd0: begin
        o_rdy = if0.tready; o_en = en0; o_data = wd0; o_ah = ah0;
        o_am = {1'b0, am0}; o_ch = c0; o_done = dn0;
      end
      2'd1: begin
        o_rdy = if1.tready; o_en = en1; o_data = wd1; o_ah = ah1;
        o_am = am1; o_ch = c1; o_done = dn1;
      end
      default: begin
        o_rdy = if2.tready; o_en = en2; o_data = wd2; o_ah = ah2;
        o_am = {1'b0, am2}; o_ch = c2; o_done = dn2;
      end
    endcase
  end

`ifdef AXIS_IN_ERR_EN
  always_comb begin
    case (sel)
      2'd0:    begin o_es = es0; o_el = el0; end
      2'd1:    begin o_es = es1; o_el = el1; end
      default: begin o_es = es2; o_el = el2; end
    endcase
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic l, input int ea, input int em, input int ec);
    int n;
    tdata  = d;
    tvalid = 1'b1;
    tlast  = l;
    n = 0;
    @(negedge clk);
    while (!o_rdy && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready", 32'(o_rdy), 32'd1);
    chk("beat_en", 32'(o_en), 32'd1);
    chk("beat_data", 32'(o_data), 32'(d));
    chk("beat_addr_h", 32'(o_ah), ea);
    chk("beat_addr_m", 32'(o_am), em);
    chk("beat_ch", 32'(o_ch), ec);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic gap(input int g);
    repeat (g) begin
      @(negedge clk);
      chk("gap_en", 32'(o_en), 32'd0);
      chk("gap_ready", 32'(o_rdy), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_done();
    @(negedge clk);
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_ready", 32'(o_rdy), 32'd0);
    chk("done_en", 32'(o_en), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(o_done), 32'd0);
    chk("idle_ready", 32'(o_rdy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int am_tab[8] = '{0, 1, 2, 4, 5, 6, 8, 9};

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(o_en), 32'd0);
    chk("rst_ready", 32'(o_rdy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_addr", 32'(o_ah), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // full frame, NCH=1, M=1
    sel = 2'd0;
    for (int i = 0; i < 8; i++) beat(16'h0010 + 16'(i), i == 7, i, i, 0);
    expect_done();
`ifdef AXIS_IN_ERR_EN
    chk("full_err_short", 32'(o_es), 32'd0);
    chk("full_err_long", 32'(o_el), 32'd0);
`endif

    // banked addressing, M=3
    sel = 2'd1;
    for (int i = 0; i < 8; i++) beat(16'h0020 + 16'(i), i == 7, i, am_tab[i], 0);
    expect_done();

    // two channels, tlast only on beat 16
    sel = 2'd2;
    for (int i = 0; i < 16; i++) beat(16'h0030 + 16'(i), i == 15, i % 8, i % 8, i / 8);
    expect_done();
`ifdef AXIS_IN_ERR_EN
    chk("nch2_err_long", 32'(o_el), 32'd0);
`endif

    // short frame: tlast on beat 3 pads addresses 3..7 with zero
    sel = 2'd0;
    for (int i = 0; i < 3; i++) beat(16'h0040 + 16'(i), i == 2, i, i, 0);
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      chk("pad_en", 32'(o_en), 32'd1);
      chk("pad_ready", 32'(o_rdy), 32'd0);
      chk("pad_data", 32'(o_data), 32'd0);
      chk("pad_addr", 32'(o_ah), k);
    end
    expect_done();
`ifdef AXIS_IN_ERR_EN
    chk("pad_err_short", 32'(o_es), 32'd1);
    chk("pad_err_long", 32'(o_el), 32'd0);
`endif

    // reset after beat 5 abandons the frame
    for (int i = 0; i < 5; i++) beat(16'h0050 + 16'(i), 1'b0, i, i, 0);
    tdata  = 16'h0055;
    tvalid = 1'b1;
    reset  = 1'b0;
    #1;
    chk("mid_rst_en", 32'(o_en), 32'd0);
    chk("mid_rst_ready", 32'(o_rdy), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    chk("mid_rst_addr", 32'(o_ah), 32'd0);
    tvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_done", 32'(o_done), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) beat(16'h0060 + 16'(i), i == 7, i, i, 0);
    expect_done();

    // NCH=2 with valid gaps and no tlast at all
    sel = 2'd2;
    for (int i = 0; i < 16; i++) begin
      beat(16'h0070 + 16'(i), 1'b0, i % 8, i % 8, i / 8);
      if (i == 0)  gap(1);
      if (i == 3)  gap(2);
      if (i == 7)  gap(3);
      if (i == 12) gap(1);
    end
    expect_done();
`ifdef AXIS_IN_ERR_EN
    chk("gap_err_long", 32'(o_el), 32'd1);
    chk("gap_err_short", 32'(o_es), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
